posit_sqrt_ctrl: RTL and testbench
==================================

# posit_sqrt_ctrl

Front-end controller for the fixed-point square-root unit in the posit datapath. Accepts one posit operand per transaction over a valid/ready handshake, decodes its sign, regime, exponent and fraction, and handles zero/NaR/negative specials by bypass. For normal operands it forms an even-scaled radicand, issues a single-cycle start to the square-root unit, captures the root on its valid pulse, and presents root plus halved scale to the posit encoder downstream.

## Interface

- `N`, 16, posit width.
- `ES`, 1, exponent field width.
- `WIDTH`, 28, radicand/root width of the square-root unit.
- `FBITS`, 27, fractional bits of radicand/root. Requires `N-3-ES <= FBITS-1`.
- `SW`, `$clog2(N)+ES+2`, signed scale width.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  operand accepted when `in_valid & in_ready`.
- `posit_in`  in  N  operand.
- `sqrt_start`  out  1  one-cycle start pulse to the square-root unit.
- `rad`  out  WIDTH  radicand, held stable from `sqrt_start` until capture.
- `sqrt_valid`  in  1  one-cycle root-valid pulse from the square-root unit.
- `sqrt_root`  in  WIDTH  root.
- `sqrt_rem`  in  WIDTH  remainder.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts.
- `out_root`  out  WIDTH  root mantissa, FBITS fractional bits.
- `out_scale`  out  SW  signed result scale (power of two).
- `out_zero`  out  1  result is zero.
- `out_nar`  out  1  result is NaR.
- `out_sticky`  out  1  inexact flag. See Configuration.

## Operation

- FSM states and transitions:
  - IDLE: `in_ready=1`. On accept, register `posit_in` and go to DECODE.
  - DECODE: one cycle. Compute fields and register `rad`, `out_scale` and the special flags. If special, go to DONE. Otherwise go to LAUNCH.
  - LAUNCH: `sqrt_start=1` for exactly this cycle, then go to WAIT.
  - WAIT: on `sqrt_valid`, capture `sqrt_root` into `out_root` (and the sticky bit), then go to DONE.
  - DONE: `out_valid=1`. On `out_ready`, go to IDLE.
- Specials:
  - `0x0…0`: `out_zero=1`, `out_root=0`, `out_scale=0`.
  - Sign bit set (this includes NaR `0x80…0`): `out_nar=1`, `out_root=0`, `out_scale=0`.
- Decode:
  - Regime run length gives k: a run of m ones gives k=m-1; a run of m zeros gives k=-m.
  - The exponent is the next ES bits, zero-padded if truncated.
  - The fraction is the remaining bits, left-aligned.
  - s = k·2^ES + e, signed SW bits.
- Radicand construction (mantissa 1.f):
  - s even: `rad` = 1.f with the hidden bit at `rad[FBITS]`; `out_scale` = s/2.
  - s odd: `rad` = 1.f/2 with the hidden bit at `rad[FBITS-1]`; `out_scale` = (s+1)/2 (arithmetic).
  - Fraction fills the bits below the hidden bit; all other bits are zero.
- `sqrt_valid` outside WAIT is ignored.
- `rad` and `out_*` hold their values until overwritten by the next transaction.

## Timing

- Reset values: state IDLE; `in_ready=1` after reset; `sqrt_start`, `out_valid`, `out_zero`, `out_nar`, `out_sticky` are 0; `rad`, `out_root`, `out_scale` are 0.
- Normal-operand timing, with accept at edge T:
  - DECODE during cycle T+1.
  - `sqrt_start` high during cycle T+2.
  - `out_valid` rises one cycle after `sqrt_valid` is sampled high.
- Special-operand timing: `out_valid` high from cycle T+2; `sqrt_start` never asserted.
- Handshake: `out_valid` holds with all `out_*` stable until `out_ready`. The earliest next accept is the cycle after the output handshake. There is no overlap of transactions.
- Reset mid-operation (any state): the FSM returns to IDLE immediately and `sqrt_start` drops. A later `sqrt_valid` from the abandoned operation is ignored.

## Configuration

- `POSIT_SQRT_STICKY_EN` defined: `out_sticky` is captured as `|sqrt_rem` in WAIT and cleared to 0 for specials.
- Not defined: `out_sticky` is tied to 0, and `sqrt_rem` is unused.

## Test plan

- `0x4000` (1.0) -> `rad=28'h8000000`, one `sqrt_start`; model returns root `28'h8000000` -> `out_root=28'h8000000`, `out_scale=0`, flags 0.
- `0x5000` (2.0, s=1) -> `rad=28'h4000000`; model root `28'h5A82799` -> `out_scale=1`; sticky=1 with macro, 0 without.
- `0x6000` (4.0, s=2) -> `rad=28'h8000000`, `out_scale=1`.
- Specials:
  - `0x0000` -> `out_zero=1`, `out_valid` at T+2, no `sqrt_start`.
  - `0x8000` and `0xC000` -> `out_nar=1`, no `sqrt_start`.
- Backpressure: hold `out_ready=0` for 5 cycles in DONE -> outputs stable and `in_ready=0`; release -> IDLE next cycle.
- Assert reset in WAIT, then inject a stray `sqrt_valid` -> state IDLE, `out_valid` stays 0, and the next operand `0x4000` completes normally.

Source files
------------

// File: rtl/posit_sqrt_ctrl.sv
// Posit square-root front end: decodes one operand, bypasses zero/NaR/negative, and sequences the root unit.
// Optional macro POSIT_SQRT_STICKY_EN: out_sticky carries |sqrt_rem; otherwise it is tied low.
module posit_sqrt_ctrl #(
    parameter int N     = 16,
    parameter int ES    = 1,
    parameter int WIDTH = 28,
    parameter int FBITS = 27,
    parameter int SW    = $clog2(N) + ES + 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     posit_in,
    output logic             sqrt_start,
    output logic [WIDTH-1:0] rad,
    input  logic             sqrt_valid,
    input  logic [WIDTH-1:0] sqrt_root,
    input  logic [WIDTH-1:0] sqrt_rem,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_root,
    output logic [SW-1:0]    out_scale,
    output logic             out_zero,
    output logic             out_nar,
    output logic             out_sticky
);

    localparam int BW = N - 1;
    localparam int FW = N - 3 - ES;
    localparam int MW = $clog2(N) + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t           state_r;
    logic [N-1:0]     opnd_r;
    logic             in_ready_r;
    logic             sqrt_start_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] rad_r;
    logic [WIDTH-1:0] out_root_r;
    logic [SW-1:0]    out_scale_r;
    logic             out_zero_r;
    logic             out_nar_r;

    logic [BW-1:0]    body_s;
    logic [BW-1:0]    rem_s;
    logic             r0_s;
    logic             run_s;
    logic [MW-1:0]    run_len_s;
    logic [ES-1:0]    exp_s;
    logic [FW-1:0]    frac_s;
    logic [SW-1:0]    k_s;
    logic [SW-1:0]    s_s;
    logic [SW-1:0]    s_adj_s;
    logic [SW-1:0]    scale_s;
    logic [WIDTH-1:0] rad_s;
    logic             zero_s;
    logic             nar_s;
    logic             unused_s;

    // Field decode of the registered operand; odd scales pre-shift the mantissa so the root scale halves exactly
    always_comb begin
        body_s    = opnd_r[BW-1:0];
        r0_s      = body_s[BW-1];
        run_s     = 1'b1;
        run_len_s = '0;
        for (int i = BW - 1; i >= 0; i--) begin
            if (run_s && (body_s[i] == r0_s)) begin
                run_len_s = run_len_s + MW'(1);
            end else begin
                run_s = 1'b0;
            end
        end
        // Dropping the regime run plus its terminator left-aligns exponent then fraction, zero-filled
        rem_s  = body_s << (run_len_s + MW'(1));
        exp_s  = rem_s[BW-1 -: ES];
        frac_s = rem_s[BW-1-ES -: FW];
        if (r0_s) begin
            k_s = SW'(run_len_s) - SW'(1);
        end else begin
            k_s = SW'(0) - SW'(run_len_s);
        end
        s_s     = (k_s << ES) + SW'(exp_s);
        s_adj_s = s_s + SW'(s_s[0]);
        scale_s = {s_adj_s[SW-1], s_adj_s[SW-1:1]};
        rad_s   = '0;
        if (s_s[0]) begin
            rad_s[FBITS-1]       = 1'b1;
            rad_s[FBITS-2 -: FW] = frac_s;
        end else begin
            rad_s[FBITS]         = 1'b1;
            rad_s[FBITS-1 -: FW] = frac_s;
        end
        zero_s = (opnd_r == '0);
        nar_s  = opnd_r[N-1];
    end

`ifdef POSIT_SQRT_STICKY_EN
    logic out_sticky_r;

    // Inexact flag: set from the remainder on capture, cleared at every decode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_sticky_r <= 1'b0;
        end else if (state_r == ST_DECODE) begin
            out_sticky_r <= 1'b0;
        end else if ((state_r == ST_WAIT) && sqrt_valid) begin
            out_sticky_r <= |sqrt_rem;
        end
    end

    assign out_sticky = out_sticky_r;
    assign unused_s   = ^rem_s[1:0];
`else
    assign out_sticky = 1'b0;
    assign unused_s   = ^{rem_s[1:0], sqrt_rem};
`endif

    // Transaction sequencer with registered handshake, start pulse and result outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            opnd_r       <= '0;
            in_ready_r   <= 1'b1;
            sqrt_start_r <= 1'b0;
            out_valid_r  <= 1'b0;
            rad_r        <= '0;
            out_root_r   <= '0;
            out_scale_r  <= '0;
            out_zero_r   <= 1'b0;
            out_nar_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        opnd_r     <= posit_in;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    out_zero_r <= zero_s;
                    out_nar_r  <= nar_s;
                    if (zero_s || nar_s) begin
                        out_root_r  <= '0;
                        out_scale_r <= '0;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        rad_r        <= rad_s;
                        out_scale_r  <= scale_s;
                        sqrt_start_r <= 1'b1;
                        state_r      <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    sqrt_start_r <= 1'b0;
                    state_r      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (sqrt_valid) begin
                        out_root_r  <= sqrt_root;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    in_ready_r   <= 1'b1;
                    sqrt_start_r <= 1'b0;
                    out_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign sqrt_start = sqrt_start_r;
    assign rad        = rad_r;
    assign out_valid  = out_valid_r;
    assign out_root   = out_root_r;
    assign out_scale  = out_scale_r;
    assign out_zero   = out_zero_r;
    assign out_nar    = out_nar_r;

endmodule

// File: tb/tb_posit_sqrt_ctrl.sv
// Self-checking bench for posit_sqrt_ctrl: directed vector table, reset/stray corner case, random operands vs a real-valued model.
module tb_posit_sqrt_ctrl;

    localparam int N  = 16;
    localparam int ES = 1;
    localparam int W  = 28;
    localparam int FB = 27;
    localparam int SW = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  posit_in;
    logic          sqrt_start;
    logic [W-1:0]  rad;
    logic          sqrt_valid;
    logic [W-1:0]  sqrt_root;
    logic [W-1:0]  sqrt_rem;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_root;
    logic [SW-1:0] out_scale;
    logic          out_zero;
    logic          out_nar;
    logic          out_sticky;

    posit_sqrt_ctrl #(.N(N), .ES(ES), .WIDTH(W), .FBITS(FB)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .posit_in(posit_in), .sqrt_start(sqrt_start), .rad(rad),
        .sqrt_valid(sqrt_valid), .sqrt_root(sqrt_root), .sqrt_rem(sqrt_rem),
        .out_valid(out_valid), .out_ready(out_ready), .out_root(out_root),
        .out_scale(out_scale), .out_zero(out_zero), .out_nar(out_nar),
        .out_sticky(out_sticky)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic longint unsigned isqrt(input longint unsigned x);
        longint unsigned r, t;
        r = 0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= x) r = t;
        end
        return r;
    endfunction

    // Reference: posit -> real value, then renormalise to a mantissa/scale pair
    function automatic void model(input logic [N-1:0] p, output logic z, output logic nr,
                                  output logic [W-1:0] rd, output int sc);
        int i, run, k, e, s;
        logic r0;
        real f, w, v, m;
        z = 1'b0; nr = 1'b0; rd = '0; sc = 0;
        if (p == 16'h0000) z = 1'b1;
        else if (p[N-1]) nr = 1'b1;
        else begin
            r0 = p[N-2]; run = 0; i = N - 2;
            while (i >= 0 && p[i] == r0) begin run++; i--; end
            k = r0 ? run - 1 : -run;
            i--;
            e = 0;
            for (int j = 0; j < ES; j++) begin
                if (i >= 0) e = 2 * e + int'(p[i]);
                else e = 2 * e;
                i--;
            end
            f = 0.0; w = 0.5;
            while (i >= 0) begin
                if (p[i]) f = f + w;
                w = w / 2.0; i--;
            end
            v = (2.0 ** (k * (1 << ES) + e)) * (1.0 + f);
            s = 0; m = v;
            while (m >= 2.0) begin m = m / 2.0; s++; end
            while (m < 1.0) begin m = m * 2.0; s--; end
            if (s % 2 != 0) begin m = m / 2.0; sc = (s + 1) / 2; end
            else sc = s / 2;
            rd = W'($rtoi(m * (2.0 ** FB)));
        end
    endfunction

    // Square-root unit stand-in: answers each start after resp_lat extra cycles
    int              resp_lat = 0;
    int              start_cnt = 0;
    bit              stray_req = 1'b0;
    bit              pend = 1'b0;
    int              cnt = 0;
    longint unsigned r_root, r_rem, r_x;

    initial begin
        sqrt_valid = 1'b0; sqrt_root = '0; sqrt_rem = '0;
        forever begin
            @(negedge clk);
            sqrt_valid = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    sqrt_valid = 1'b1;
                    sqrt_root  = r_root[W-1:0];
                    sqrt_rem   = r_rem[W-1:0];
                    pend       = 1'b0;
                end else cnt--;
            end else if (stray_req) begin
                sqrt_valid = 1'b1;
                sqrt_root  = 28'h1234567;
                sqrt_rem   = 28'h0000001;
                stray_req  = 1'b0;
            end
            if (sqrt_start === 1'b1) begin
                start_cnt++;
                r_x    = 64'(rad) << FB;
                r_root = isqrt(r_x);
                r_rem  = r_x - r_root * r_root;
                pend   = 1'b1;
                cnt    = resp_lat;
            end
        end
    end

    // One full transaction, starting and ending just after a falling edge
    task automatic do_txn(input logic [N-1:0] p, input int lat, input int hold,
                          input logic ez, input logic en, input logic [W-1:0] erad,
                          input int escale, input logic [W-1:0] eroot);
        int  cyc, s0;
        bit  special;
        logic est;
        longint unsigned x;
        special = ez | en;
        x = 64'(erad) << FB;
`ifdef POSIT_SQRT_STICKY_EN
        est = special ? 1'b0 : ((x - 64'(eroot) * 64'(eroot)) != 0);
`else
        est = 1'b0;
`endif
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        chk("accept_ready", in_ready, 1);
        resp_lat = lat; s0 = start_cnt;
        posit_in = p; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; posit_in = N'($urandom);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (out_valid !== 1'b1 && cyc < 40);
        chk($sformatf("latency_%h", p), cyc, special ? 2 : 4 + lat);
        chk($sformatf("starts_%h", p), start_cnt - s0, special ? 0 : 1);
        chk($sformatf("zero_%h", p), out_zero, ez);
        chk($sformatf("nar_%h", p), out_nar, en);
        chk($sformatf("scale_%h", p), longint'($signed(out_scale)), escale);
        chk($sformatf("root_%h", p), out_root, eroot);
        chk($sformatf("sticky_%h", p), out_sticky, est);
        if (!special) chk($sformatf("rad_%h", p), rad, erad);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_inready", in_ready, 0);
            chk("hold_root", out_root, eroot);
            chk("hold_scale", longint'($signed(out_scale)), escale);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("release_valid", out_valid, 0);
        chk("release_ready", in_ready, 1);
    endtask

    typedef struct {
        logic [N-1:0] p;
        int           lat;
        int           hold;
        logic         z;
        logic         nr;
        logic [W-1:0] rd;
        int           sc;
        logic [W-1:0] root;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, sc;
        logic mz, mn;
        logic [W-1:0] mrad;
        logic [N-1:0] p;
        longint unsigned mroot;

        vecs[0] = '{16'h4000, 0, 5, 1'b0, 1'b0, 28'h8000000,   0, 28'h8000000};
        vecs[1] = '{16'h5000, 1, 0, 1'b0, 1'b0, 28'h4000000,   1, 28'h5A82799};
        vecs[2] = '{16'h6000, 2, 1, 1'b0, 1'b0, 28'h8000000,   1, 28'h8000000};
        vecs[3] = '{16'h0000, 0, 0, 1'b1, 1'b0, 28'h0000000,   0, 28'h0000000};
        vecs[4] = '{16'h8000, 0, 0, 1'b0, 1'b1, 28'h0000000,   0, 28'h0000000};
        vecs[5] = '{16'hC000, 0, 2, 1'b0, 1'b1, 28'h0000000,   0, 28'h0000000};
        vecs[6] = '{16'h7FFF, 3, 0, 1'b0, 1'b0, 28'h8000000,  14, 28'h8000000};
        vecs[7] = '{16'h0001, 0, 0, 1'b0, 1'b0, 28'h8000000, -14, 28'h8000000};
        vecs[8] = '{16'h3000, 0, 0, 1'b0, 1'b0, 28'h4000000,   0, 28'h5A82799};
        vecs[9] = '{16'h2000, 1, 0, 1'b0, 1'b0, 28'h8000000,  -1, 28'h8000000};

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; posit_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_start", sqrt_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rad", rad, 0);
        chk("rst_root", out_root, 0);
        chk("rst_scale", out_scale, 0);
        chk("rst_flags", {out_zero, out_nar, out_sticky}, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);

        for (int v = 0; v < 10; v++)
            do_txn(vecs[v].p, vecs[v].lat, vecs[v].hold, vecs[v].z, vecs[v].nr,
                   vecs[v].rd, vecs[v].sc, vecs[v].root);

        // Reset while waiting for the root, then the abandoned and an extra stray valid arrive
        resp_lat = 8; posit_in = 16'h4000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        bad = start_cnt; sc = 0;
        do begin @(negedge clk); sc++; end while (start_cnt == bad && sc < 10);
        chk("abandon_started", start_cnt - bad, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_start", sqrt_start, 0);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_valid", out_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 8) stray_req = 1'b1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || sqrt_start !== 1'b0) bad++;
        end
        chk("stray_ignored", bad, 0);
        do_txn(16'h4000, 0, 0, 1'b0, 1'b0, 28'h8000000, 0, 28'h8000000);

        for (int t = 0; t < 60; t++) begin
            p = N'($urandom);
            if (t % 15 == 0) p = 16'h0000;
            model(p, mz, mn, mrad, sc);
            mroot = (mz | mn) ? 64'd0 : isqrt(64'(mrad) << FB);
            do_txn(p, $urandom_range(0, 3), $urandom_range(0, 2), mz, mn, mrad, sc, mroot[W-1:0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
